if_prefetch_queue: RTL

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

---
 rtl/if_prefetch_queue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches under a credit limit,
// tracks in-flight addresses, and buffers in-order responses for decode.
module if_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic [XLEN-1:0]            i_flush_pc,
    output logic                       o_req_valid,
    input  logic                       i_req_ready,
    output logic [XLEN-1:0]            o_req_addr,
    input  logic                       i_rsp_valid,
    input  logic [XLEN-1:0]            i_rsp_data,
    output logic                       o_if_valid,
    input  logic                       i_id_ready,
    output logic [XLEN-1:0]            o_if_inst,
    output logic [XLEN-1:0]            o_if_pc,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Fetch PC and credit accounting
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;

    // Address FIFO: one entry per accepted request, popped by each response
    logic [XLEN-1:0] af_addr_q [DEPTH];
    logic [AW-1:0]   af_head_q, af_head_d;
    logic [AW-1:0]   af_tail_q, af_tail_d;

    // Instruction queue
    logic [XLEN-1:0] iq_inst_q [DEPTH];
    logic [XLEN-1:0] iq_pc_q   [DEPTH];
    logic [AW-1:0]   iq_head_q, iq_head_d;
    logic [AW-1:0]   iq_tail_q, iq_tail_d;
    logic [CW-1:0]   iq_count_q, iq_count_d;

    logic [CW:0] occupancy;
    logic        credit_ok;
    logic        req_valid;
    logic        req_fire;
    logic        rsp_fire;
    logic        rsp_keep;
    logic        if_valid;
    logic        if_pop;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // The request side never withdraws valid or changes the address while
    // waiting (credit only grows while stalled); only a flush can cancel it.
    always_comb begin
        occupancy = {1'b0, iq_count_q} + {1'b0, outst_q};
        credit_ok = occupancy < (CW+1)'(DEPTH);
        req_valid = rst_n && !i_flush && credit_ok;
        req_fire  = req_valid && i_req_ready;
        rsp_fire  = i_rsp_valid && (outst_q != '0);
        rsp_keep  = rsp_fire && !i_flush && (discard_q == '0);
        if_valid  = (iq_count_q != '0);
        if_pop    = if_valid && i_id_ready && !i_flush;
    end

    always_comb begin
        pc_d       = pc_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(rsp_fire);
        discard_d  = discard_q;
        af_head_d  = af_head_q + AW'(rsp_fire);
        af_tail_d  = af_tail_q + AW'(req_fire);
        iq_head_d  = iq_head_q + AW'(if_pop);
        iq_tail_d  = iq_tail_q + AW'(rsp_keep);
        iq_count_d = iq_count_q + CW'(rsp_keep) - CW'(if_pop);

        if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end

        if (rsp_fire && !i_flush && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end

        // Everything still in flight after this edge belongs to the old path.
        if (i_flush) begin
            pc_d       = i_flush_pc;
            discard_d  = outst_q - CW'(rsp_fire);
            iq_head_d  = '0;
            iq_tail_d  = '0;
            iq_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            af_head_q  <= '0;
            af_tail_q  <= '0;
            iq_head_q  <= '0;
            iq_tail_q  <= '0;
            iq_count_q <= '0;
        end else begin
            pc_q       <= pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            af_head_q  <= af_head_d;
            af_tail_q  <= af_tail_d;
            iq_head_q  <= iq_head_d;
            iq_tail_q  <= iq_tail_d;
            iq_count_q <= iq_count_d;
        end
    end

    // Storage arrays need no reset: outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            af_addr_q[af_tail_q] <= pc_q;
        end
        if (rsp_keep) begin
            iq_inst_q[iq_tail_q] <= i_rsp_data;
            iq_pc_q[iq_tail_q]   <= af_addr_q[af_head_q];
        end
    end

    assign o_req_valid = req_valid;
    assign o_req_addr  = pc_q;
    assign o_if_valid  = if_valid;
    assign o_if_inst   = if_valid ? iq_inst_q[iq_head_q] : '0;
    assign o_if_pc     = if_valid ? iq_pc_q[iq_head_q] : '0;
    assign o_count     = iq_count_q;

    rsp_without_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) !(i_rsp_valid && (outst_q == '0))
    );

endmodule
